// File: rtl/mmio_intr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mmio_intr_ctrl
//  Purpose  : Memory-mapped interrupt controller. NUM_SRC maskable sources,
//             fixed priority (source 0 highest), per-source edge/level mode,
//             software-raised interrupts, single-level (non-nesting) service
//             with acknowledge from the CPU and end-of-interrupt by register
//             write.
//  Ports    : clk      - system clock, rising edge
//             resetn   - asynchronous active-low reset
//             src      - raw request lines (asynchronous to clk)
//             addr     - MEM-stage byte address
//             datain   - MEM-stage store data
//             we       - MEM-stage store strobe
//             dataout  - register read data, combinational from addr
//             intr     - interrupt request to the CPU
//             inta     - single-cycle acknowledge from the CPU
//             irq_id   - in-service source ID
//  Register map (addr[4:0]):
//             0x00 PEND  (W1C, edge bits only)   0x04 EN
//             0x08 MODE  (1 = edge)              0x0C VEC {in_service,0,id}
//             0x10 EOI   (write clears service)  0x14 SWINT (edge bits only)
//  Revision : 1.0 - initial release
// ============================================================================
module mmio_intr_ctrl #(
   parameter int          NUM_SRC = 8,
   parameter logic [15:0] BASE_HI = 16'hBF80
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [NUM_SRC-1:0] src,
   input  logic [31:0]        addr,
   input  logic [31:0]        datain,
   input  logic               we,
   output logic [31:0]        dataout,
   output logic               intr,
   input  logic               inta,
   output logic [4:0]         irq_id
);

   // Register selects, addr[4:2]
   localparam logic [2:0] c_sel_pend  = 3'd0;
   localparam logic [2:0] c_sel_en    = 3'd1;
   localparam logic [2:0] c_sel_mode  = 3'd2;
   localparam logic [2:0] c_sel_vec   = 3'd3;
   localparam logic [2:0] c_sel_eoi   = 3'd4;
   localparam logic [2:0] c_sel_swint = 3'd5;

   localparam logic [NUM_SRC-1:0] c_one = NUM_SRC'(1);

   logic [NUM_SRC-1:0] r_sync1;
   logic [NUM_SRC-1:0] r_sync2;
   logic [NUM_SRC-1:0] r_prev;
   logic [NUM_SRC-1:0] r_pend_edge;
   logic [NUM_SRC-1:0] r_en;
   logic [NUM_SRC-1:0] r_mode;
   logic               r_in_service;
   logic [4:0]         r_irq_id;

   logic               w_hit;
   logic [2:0]         w_sel;
   logic               w_wr_pend;
   logic               w_wr_en;
   logic               w_wr_mode;
   logic               w_wr_eoi;
   logic               w_wr_swint;
   logic [NUM_SRC-1:0] w_wdata;
   logic [NUM_SRC-1:0] w_pend;
   logic [NUM_SRC-1:0] w_req;
   logic [NUM_SRC-1:0] w_win_oh;
   logic [4:0]         w_win_id;
   logic               w_busy;
   logic               w_ack;
   logic [NUM_SRC-1:0] w_set;
   logic [NUM_SRC-1:0] w_clr;
   logic [31:0]        w_pend_rd;
   logic [31:0]        w_en_rd;
   logic [31:0]        w_mode_rd;
   logic               w_unused_bits;

   // ------------------------------------------------------------------
   // Address decode. addr[15:5] and addr[1:0] do not take part.
   // ------------------------------------------------------------------
   assign w_hit      = (addr[31:16] == BASE_HI);
   assign w_sel      = addr[4:2];
   assign w_wdata    = datain[NUM_SRC-1:0];
   assign w_wr_pend  = we & w_hit & (w_sel == c_sel_pend);
   assign w_wr_en    = we & w_hit & (w_sel == c_sel_en);
   assign w_wr_mode  = we & w_hit & (w_sel == c_sel_mode);
   assign w_wr_eoi   = we & w_hit & (w_sel == c_sel_eoi);
   assign w_wr_swint = we & w_hit & (w_sel == c_sel_swint);

   assign w_unused_bits = ^{addr[15:5], addr[1:0], datain[31:NUM_SRC]};

   // ------------------------------------------------------------------
   // Pending view: edge bits come from the stored register, level bits
   // track the synchronised line directly. Because the stored register is
   // forced to zero while a bit is in level mode, switching edge->level
   // discards the stored bit and the level shows up straight away.
   // ------------------------------------------------------------------
   assign w_pend = (r_pend_edge & r_mode) | (r_sync2 & ~r_mode);
   assign w_req  = w_pend & r_en;

   // Lowest set bit wins.
   assign w_win_oh = w_req & (~w_req + c_one);

   always_comb begin
      w_win_id = 5'd0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (w_req[i]) begin
            w_win_id = 5'(i);
         end
      end
   end

   // An EOI written in the same cycle as inta is applied first, so the
   // acknowledge sees the controller as idle.
   assign w_busy = r_in_service & ~w_wr_eoi;
   assign w_ack  = inta & (|w_req) & ~w_busy;

   assign intr   = (|w_req) & ~r_in_service;
   assign irq_id = r_irq_id;

   // Sets (hardware edge, SWINT) override clears (W1C, acknowledge).
   assign w_set = (r_sync2 & ~r_prev & r_mode)
                | ((w_wr_swint ? w_wdata : '0) & r_mode);
   assign w_clr = (w_wr_pend ? w_wdata : '0)
                | (w_ack ? w_win_oh : '0);

   // ------------------------------------------------------------------
   // Source synchroniser and edge-detect history
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_prev  <= '0;
      end else begin
         r_sync1 <= src;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   // ------------------------------------------------------------------
   // Control registers and service state
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_pend_edge  <= '0;
         r_en         <= '0;
         r_mode       <= '0;
         r_in_service <= 1'b0;
         r_irq_id     <= 5'd0;
      end else begin
         r_pend_edge <= ((r_pend_edge & ~w_clr) | w_set) & r_mode;
         if (w_wr_en) begin
            r_en <= w_wdata;
         end
         if (w_wr_mode) begin
            r_mode <= w_wdata;
         end
         if (w_ack) begin
            r_in_service <= 1'b1;
            r_irq_id     <= w_win_id;
         end else if (w_wr_eoi) begin
            r_in_service <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Read mux. Bits at NUM_SRC and above read as zero.
   // ------------------------------------------------------------------
   assign w_pend_rd = {{(32-NUM_SRC){1'b0}}, w_pend};
   assign w_en_rd   = {{(32-NUM_SRC){1'b0}}, r_en};
   assign w_mode_rd = {{(32-NUM_SRC){1'b0}}, r_mode};

   always_comb begin
      dataout = 32'd0;
      if (w_hit) begin
         case (w_sel)
            c_sel_pend: dataout = w_pend_rd;
            c_sel_en:   dataout = w_en_rd;
            c_sel_mode: dataout = w_mode_rd;
            c_sel_vec:  dataout = {r_in_service, 26'd0, r_irq_id};
            default:    dataout = 32'd0;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mmio_intr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mmio_intr_ctrl
//  Purpose  : Directed bench for mmio_intr_ctrl. Stimulus pushes expected
//             values into a queue; a monitor drains the queue on each
//             falling clock edge and compares against the DUT outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_intr_ctrl;

   localparam int          NUM_SRC = 8;
   localparam logic [31:0] BASE    = 32'hBF80_0000;

   localparam int K_DOUT = 0;
   localparam int K_INTR = 1;
   localparam int K_ID   = 2;

   typedef struct {
      string       name;
      int          kind;
      logic [31:0] exp;
   } item_t;

   logic               clk;
   logic               resetn;
   logic [NUM_SRC-1:0] src;
   logic [31:0]        addr;
   logic [31:0]        datain;
   logic               we;
   logic [31:0]        dataout;
   logic               intr;
   logic               inta;
   logic [4:0]         irq_id;

   item_t q[$];
   int    n_pass;
   int    n_total;

   mmio_intr_ctrl #(
      .NUM_SRC (NUM_SRC),
      .BASE_HI (16'hBF80)
   ) dut (
      .clk     (clk),
      .resetn  (resetn),
      .src     (src),
      .addr    (addr),
      .datain  (datain),
      .we      (we),
      .dataout (dataout),
      .intr    (intr),
      .inta    (inta),
      .irq_id  (irq_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------------
   // Monitor: compare every queued expectation at the falling edge
   // ------------------------------------------------------------------
   initial begin
      item_t it;
      logic [31:0] got;
      forever begin
         @(negedge clk);
         while (q.size() > 0) begin
            it = q.pop_front();
            case (it.kind)
               K_DOUT:  got = dataout;
               K_INTR:  got = {31'd0, intr};
               default: got = {27'd0, irq_id};
            endcase
            n_total++;
            if (got === it.exp) begin
               n_pass++;
            end else begin
               $display("FAIL %s: got %h expected %h", it.name, got, it.exp);
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string name, input int kind, input logic [31:0] exp);
      item_t it;
      it.name = name;
      it.kind = kind;
      it.exp  = exp;
      q.push_back(it);
   endtask

   task automatic wr(input logic [4:0] off, input logic [31:0] data);
      addr   = BASE | {27'd0, off};
      datain = data;
      we     = 1'b1;
      tick();
      we     = 1'b0;
      addr   = 32'd0;
      datain = 32'd0;
   endtask

   task automatic chk_rd(input logic [31:0] a, input logic [31:0] exp, input string name);
      addr = a;
      push(name, K_DOUT, exp);
      tick();
      addr = 32'd0;
   endtask

   task automatic chk_intr(input logic exp, input string name);
      push(name, K_INTR, {31'd0, exp});
   endtask

   task automatic chk_id(input logic [4:0] exp, input string name);
      push(name, K_ID, {27'd0, exp});
   endtask

   task automatic ack();
      inta = 1'b1;
      tick();
      inta = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   // ------------------------------------------------------------------
   // Directed sequence
   // ------------------------------------------------------------------
   initial begin
      n_pass  = 0;
      n_total = 0;
      resetn  = 1'b0;
      src     = 8'hFF;
      addr    = 32'd0;
      datain  = 32'd0;
      we      = 1'b0;
      inta    = 1'b0;
      tick();

      // Reset state: every offset reads 0, no request
      chk_intr(1'b0, "rst_intr");
      chk_id(5'd0, "rst_id");
      for (int i = 0; i < 8; i++) begin
         chk_rd(BASE | (i * 4), 32'd0, "rst_rd");
      end

      resetn = 1'b1;
      tick();
      tick();
      tick();
      chk_intr(1'b0, "en0_intr");
      chk_rd(BASE | 32'h00, 32'h0000_00FF, "level_pend_ff");
      wr(5'h04, 32'h01);
      chk_intr(1'b1, "en1_intr");
      chk_rd(BASE | 32'h04, 32'h0000_0001, "en_rd");
      chk_intr(1'b1, "en1_intr_later");
      tick();

      // Edge mode, single-cycle pulse on src[5]
      src = 8'h00;
      tick();
      tick();
      tick();
      wr(5'h08, 32'hFF);
      wr(5'h04, 32'hFF);
      tick();
      tick();
      chk_intr(1'b0, "edge_idle_intr");
      chk_rd(BASE | 32'h08, 32'h0000_00FF, "mode_rd");
      src = 8'h20;
      tick();
      src = 8'h00;
      tick();
      chk_rd(BASE | 32'h00, 32'h0, "pulse_pend_early");
      chk_intr(1'b1, "pulse_intr");
      chk_rd(BASE | 32'h00, 32'h20, "pulse_pend");
      ack();
      chk_intr(1'b0, "ack5_intr");
      chk_id(5'd5, "ack5_id");
      chk_rd(BASE | 32'h00, 32'h0, "ack5_pend");
      chk_rd(BASE | 32'h0C, 32'h8000_0005, "ack5_vec");
      wr(5'h10, 32'h0);
      chk_intr(1'b0, "eoi5_intr");
      chk_rd(BASE | 32'h0C, 32'h0000_0005, "eoi5_vec");
      ack();  // no request: ignored
      chk_rd(BASE | 32'h0C, 32'h0000_0005, "stray_ack_vec");

      // Simultaneous edges on src[6] and src[2]
      src = 8'h44;
      tick();
      src = 8'h00;
      tick();
      tick();
      chk_intr(1'b1, "two_intr");
      chk_rd(BASE | 32'h00, 32'h44, "two_pend");
      ack();
      chk_id(5'd2, "two_id2");
      chk_intr(1'b0, "two_ack_intr");
      chk_rd(BASE | 32'h00, 32'h40, "two_pend_after");
      // EOI and inta in the same cycle: acknowledge of source 6 is taken
      addr  = BASE | 32'h10;
      we    = 1'b1;
      inta  = 1'b1;
      tick();
      we    = 1'b0;
      inta  = 1'b0;
      addr  = 32'd0;
      chk_id(5'd6, "eoi_ack_id6");
      chk_intr(1'b0, "eoi_ack_intr");
      chk_rd(BASE | 32'h0C, 32'h8000_0006, "eoi_ack_vec");
      chk_rd(BASE | 32'h00, 32'h0, "eoi_ack_pend");
      wr(5'h10, 32'h0);
      chk_intr(1'b0, "two_done_intr");

      // Software interrupt and W1C
      wr(5'h04, 32'h08);
      wr(5'h08, 32'h08);
      wr(5'h14, 32'h08);
      chk_intr(1'b1, "swint_intr");
      chk_rd(BASE | 32'h00, 32'h08, "swint_pend");
      wr(5'h00, 32'h08);
      chk_intr(1'b0, "w1c_intr");
      chk_rd(BASE | 32'h00, 32'h0, "w1c_pend");
      wr(5'h14, 32'h02);  // level-mode bit: no effect
      chk_rd(BASE | 32'h00, 32'h0, "swint_level_pend");
      wr(5'h14, 32'h08);
      // SWINT set and acknowledge clear on the same bit: set wins
      addr   = BASE | 32'h14;
      datain = 32'h08;
      we     = 1'b1;
      inta   = 1'b1;
      tick();
      we     = 1'b0;
      inta   = 1'b0;
      addr   = 32'd0;
      datain = 32'd0;
      chk_id(5'd3, "setwin_id");
      chk_intr(1'b0, "setwin_intr");
      chk_rd(BASE | 32'h00, 32'h08, "setwin_pend");
      wr(5'h00, 32'h08);
      wr(5'h10, 32'h0);
      chk_intr(1'b0, "swint_done_intr");
      // Edge -> level discards the stored bit
      wr(5'h14, 32'h08);
      chk_rd(BASE | 32'h00, 32'h08, "pre_mode_pend");
      wr(5'h08, 32'h00);
      chk_intr(1'b0, "mode_lvl_intr");
      chk_rd(BASE | 32'h00, 32'h0, "mode_lvl_pend");

      // Level source src[1]
      wr(5'h04, 32'h02);
      src = 8'h02;
      tick();
      tick();
      chk_intr(1'b1, "lvl_intr");
      ack();
      chk_id(5'd1, "lvl_id");
      chk_intr(1'b0, "lvl_ack_intr");
      chk_rd(BASE | 32'h00, 32'h02, "lvl_ack_pend");
      wr(5'h10, 32'h0);
      chk_intr(1'b1, "lvl_eoi_intr");
      wr(5'h00, 32'h02);
      chk_rd(BASE | 32'h00, 32'h02, "lvl_w1c_pend");
      chk_intr(1'b1, "lvl_w1c_intr");

      // Address misses
      chk_rd(32'hBF81_0004, 32'h0, "miss_rd");
      addr   = 32'hBF90_0004;
      datain = 32'h0;
      we     = 1'b1;
      tick();
      we     = 1'b0;
      addr   = 32'd0;
      chk_rd(BASE | 32'h04, 32'h02, "miss_wr_en");

      // Asynchronous reset while in service
      ack();
      resetn = 1'b0;
      addr   = BASE | 32'h0C;
      chk_intr(1'b0, "areset_intr");
      chk_id(5'd0, "areset_id");
      push("areset_vec", K_DOUT, 32'h0);
      tick();
      chk_rd(BASE | 32'h00, 32'h0, "areset_pend");
      chk_rd(BASE | 32'h04, 32'h0, "areset_en");
      chk_rd(BASE | 32'h08, 32'h0, "areset_mode");
      resetn = 1'b1;
      tick();
      tick();

      if (q.size() != 0) begin
         n_total++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
